// File: rtl/axi4_lite_s_mem.sv
// AXI4-Lite responder backed by a word-addressed, byte-writable memory.
// Independent read and write state machines, one transaction outstanding each.
module axi4_lite_s_mem #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           MASK_WIDTH = 4,
  parameter int unsigned           RESP_WIDTH = 2,
  parameter int unsigned           DEPTH_LOG2 = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(32'h8000_0000),
  parameter int unsigned           RD_LAT     = 2
) (
  input  logic                  iClock,
  input  logic                  iReset,
  input  logic                  pAXI4S_ar_valid,
  output logic                  pAXI4S_ar_ready,
  input  logic [ADDR_WIDTH-1:0] pAXI4S_ar_bits_addr,
  output logic                  pAXI4S_r_valid,
  input  logic                  pAXI4S_r_ready,
  output logic [DATA_WIDTH-1:0] pAXI4S_r_bits_data,
  output logic [RESP_WIDTH-1:0] pAXI4S_r_bits_resp,
  input  logic                  pAXI4S_aw_valid,
  output logic                  pAXI4S_aw_ready,
  input  logic [ADDR_WIDTH-1:0] pAXI4S_aw_bits_addr,
  input  logic                  pAXI4S_w_valid,
  output logic                  pAXI4S_w_ready,
  input  logic [DATA_WIDTH-1:0] pAXI4S_w_bits_data,
  input  logic [MASK_WIDTH-1:0] pAXI4S_w_bits_strb,
  output logic                  pAXI4S_b_valid,
  input  logic                  pAXI4S_b_ready,
  output logic [RESP_WIDTH-1:0] pAXI4S_b_bits_resp
);

  localparam int unsigned WORDS  = 1 << DEPTH_LOG2;
  localparam int unsigned TAG_LO = DEPTH_LOG2 + 2;
  localparam int unsigned CNT_W  = 4;
  localparam logic [RESP_WIDTH-1:0] RESP_OKAY   = RESP_WIDTH'(0);
  localparam logic [RESP_WIDTH-1:0] RESP_DECERR = RESP_WIDTH'(3);

  typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_RESP} rd_state_e;
  typedef enum logic [1:0] {WR_IDLE, WR_COMMIT, WR_RESP} wr_state_e;

  logic [DATA_WIDTH-1:0] mem_q [WORDS];

  rd_state_e             rd_state_q;
  logic [CNT_W-1:0]      rd_cnt_q;
  logic                  r_valid_q;
  logic [DATA_WIDTH-1:0] r_data_q;
  logic [RESP_WIDTH-1:0] r_resp_q;

  wr_state_e             wr_state_q;
  logic                  aw_got_q, w_got_q, aw_hit_q;
  logic [DEPTH_LOG2-1:0] aw_idx_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [MASK_WIDTH-1:0] w_strb_q;
  logic                  b_valid_q;
  logic [RESP_WIDTH-1:0] b_resp_q;

  logic                  ar_hit, aw_hit, ar_fire, aw_fire, w_fire;
  logic [DEPTH_LOG2-1:0] ar_idx, aw_idx;
  logic                  unused_addr_bits;

  function automatic logic addr_hit(input logic [ADDR_WIDTH-1:0] a);
    return a[ADDR_WIDTH-1:TAG_LO] == BASE_ADDR[ADDR_WIDTH-1:TAG_LO];
  endfunction

  // addr[1:0] never selects anything: accesses are word-aligned
  assign unused_addr_bits = ^{pAXI4S_ar_bits_addr[1:0], pAXI4S_aw_bits_addr[1:0]};

  assign ar_hit = addr_hit(pAXI4S_ar_bits_addr);
  assign aw_hit = addr_hit(pAXI4S_aw_bits_addr);
  assign ar_idx = pAXI4S_ar_bits_addr[DEPTH_LOG2+1:2];
  assign aw_idx = pAXI4S_aw_bits_addr[DEPTH_LOG2+1:2];

  // Readies come from state only, forced low while reset is held
  assign pAXI4S_ar_ready = !iReset && (rd_state_q == RD_IDLE);
  assign pAXI4S_aw_ready = !iReset && (wr_state_q == WR_IDLE) && !aw_got_q;
  assign pAXI4S_w_ready  = !iReset && (wr_state_q == WR_IDLE) && !w_got_q;

  assign ar_fire = pAXI4S_ar_valid && pAXI4S_ar_ready;
  assign aw_fire = pAXI4S_aw_valid && pAXI4S_aw_ready;
  assign w_fire  = pAXI4S_w_valid  && pAXI4S_w_ready;

  assign pAXI4S_r_valid     = r_valid_q;
  assign pAXI4S_r_bits_data = r_data_q;
  assign pAXI4S_r_bits_resp = r_resp_q;
  assign pAXI4S_b_valid     = b_valid_q;
  assign pAXI4S_b_bits_resp = b_resp_q;

  // Read FSM: data is captured at AR acceptance, then delayed by the counter
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      rd_state_q <= RD_IDLE;
      rd_cnt_q   <= '0;
      r_valid_q  <= 1'b0;
      r_data_q   <= '0;
      r_resp_q   <= '0;
    end else begin
      unique case (rd_state_q)
        RD_IDLE: if (ar_fire) begin
          r_data_q   <= ar_hit ? mem_q[ar_idx] : '0;
          r_resp_q   <= ar_hit ? RESP_OKAY : RESP_DECERR;
          rd_cnt_q   <= CNT_W'(RD_LAT - 1);
          rd_state_q <= RD_WAIT;
        end
        RD_WAIT: begin
          if (rd_cnt_q == '0) begin
            r_valid_q  <= 1'b1;
            rd_state_q <= RD_RESP;
          end else begin
            rd_cnt_q <= rd_cnt_q - CNT_W'(1);
          end
        end
        RD_RESP: if (pAXI4S_r_ready) begin
          r_valid_q  <= 1'b0;
          rd_state_q <= RD_IDLE;
        end
        default: rd_state_q <= RD_IDLE;
      endcase
    end
  end

  // Write FSM: AW and W are collected independently, committed together
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      wr_state_q <= WR_IDLE;
      aw_got_q   <= 1'b0;
      w_got_q    <= 1'b0;
      aw_hit_q   <= 1'b0;
      aw_idx_q   <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      b_valid_q  <= 1'b0;
      b_resp_q   <= '0;
    end else begin
      unique case (wr_state_q)
        WR_IDLE: begin
          if (aw_fire) begin
            aw_got_q <= 1'b1;
            aw_hit_q <= aw_hit;
            aw_idx_q <= aw_idx;
          end
          if (w_fire) begin
            w_got_q  <= 1'b1;
            w_data_q <= pAXI4S_w_bits_data;
            w_strb_q <= pAXI4S_w_bits_strb;
          end
          if ((aw_got_q || aw_fire) && (w_got_q || w_fire)) wr_state_q <= WR_COMMIT;
        end
        WR_COMMIT: begin
          b_valid_q  <= 1'b1;
          b_resp_q   <= aw_hit_q ? RESP_OKAY : RESP_DECERR;
          aw_got_q   <= 1'b0;
          w_got_q    <= 1'b0;
          wr_state_q <= WR_RESP;
        end
        WR_RESP: if (pAXI4S_b_ready) begin
          b_valid_q  <= 1'b0;
          wr_state_q <= WR_IDLE;
        end
        default: wr_state_q <= WR_IDLE;
      endcase
    end
  end

  // Storage is intentionally not reset
  always_ff @(posedge iClock) begin
    if (wr_state_q == WR_COMMIT && aw_hit_q) begin
      for (int i = 0; i < MASK_WIDTH; i++) begin
        if (w_strb_q[i]) mem_q[aw_idx_q][i*8 +: 8] <= w_data_q[i*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi4_lite_s_mem.sv
// Directed self-checking bench for axi4_lite_s_mem.
module tb_axi4_lite_s_mem;

  localparam int unsigned RD_LAT = 2;

  logic        clk, rst;
  logic        ar_valid, ar_ready, r_valid, r_ready;
  logic [31:0] ar_addr, r_data;
  logic [1:0]  r_resp;
  logic        aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
  logic [31:0] aw_addr, w_data;
  logic [3:0]  w_strb;
  logic [1:0]  b_resp;

  int n_assert = 0;
  int n_fail   = 0;

  axi4_lite_s_mem #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MASK_WIDTH(4), .RESP_WIDTH(2),
    .DEPTH_LOG2(8), .BASE_ADDR(32'h8000_0000), .RD_LAT(RD_LAT)
  ) dut (
    .iClock(clk), .iReset(rst),
    .pAXI4S_ar_valid(ar_valid), .pAXI4S_ar_ready(ar_ready), .pAXI4S_ar_bits_addr(ar_addr),
    .pAXI4S_r_valid(r_valid), .pAXI4S_r_ready(r_ready),
    .pAXI4S_r_bits_data(r_data), .pAXI4S_r_bits_resp(r_resp),
    .pAXI4S_aw_valid(aw_valid), .pAXI4S_aw_ready(aw_ready), .pAXI4S_aw_bits_addr(aw_addr),
    .pAXI4S_w_valid(w_valid), .pAXI4S_w_ready(w_ready),
    .pAXI4S_w_bits_data(w_data), .pAXI4S_w_bits_strb(w_strb),
    .pAXI4S_b_valid(b_valid), .pAXI4S_b_ready(b_ready), .pAXI4S_b_bits_resp(b_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge
  task automatic wr(input string tag, input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] s, input int w_lead, input int b_hold,
                    input logic [1:0] exp_resp);
    int n, lat;
    logic aw_hs, w_hs;
    aw_addr = a; w_data = d; w_strb = s; b_ready = (b_hold == 0);
    w_valid = 1'b1; aw_valid = (w_lead == 0);
    for (int i = 0; i < w_lead; i++) begin
      w_hs = w_valid && w_ready;
      @(negedge clk);
      if (w_hs) w_valid = 1'b0;
      if (!w_valid) chk({tag, " w_ready after W"}, 32'(w_ready), 0);
    end
    aw_valid = 1'b1;
    n = 0;
    while ((aw_valid || w_valid) && n < 50) begin
      aw_hs = aw_valid && aw_ready;
      w_hs  = w_valid && w_ready;
      @(negedge clk);
      n++;
      if (aw_hs) aw_valid = 1'b0;
      if (w_hs)  w_valid  = 1'b0;
    end
    chk({tag, " aw/w accepted"}, 32'(aw_valid || w_valid), 0);
    aw_valid = 1'b0; w_valid = 1'b0;
    lat = 0;
    while (!b_valid && lat < 50) begin
      chk({tag, " w_ready busy"}, 32'(w_ready), 0);
      @(negedge clk);
      lat++;
    end
    chk({tag, " b latency"}, 32'(lat), 1);
    chk({tag, " bresp"}, 32'(b_resp), 32'(exp_resp));
    for (int i = 0; i < b_hold; i++) begin
      @(negedge clk);
      chk({tag, " b_valid held"}, 32'(b_valid), 1);
      chk({tag, " bresp held"}, 32'(b_resp), 32'(exp_resp));
      chk({tag, " w_ready held low"}, 32'(w_ready), 0);
    end
    b_ready = 1'b1;
    @(negedge clk);
    b_ready = 1'b0;
    chk({tag, " b_valid drop"}, 32'(b_valid), 0);
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input int r_hold,
                    input logic [31:0] exp_d, input logic [1:0] exp_r);
    int n, lat;
    ar_addr = a; ar_valid = 1'b1; r_ready = (r_hold == 0);
    n = 0;
    while (!ar_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " ar accepted"}, 32'(ar_ready), 1);
    @(negedge clk);
    ar_valid = 1'b0;
    lat = 0;
    while (!r_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, " r latency"}, 32'(lat), RD_LAT);
    chk({tag, " rdata"}, r_data, exp_d);
    chk({tag, " rresp"}, 32'(r_resp), 32'(exp_r));
    for (int i = 0; i < r_hold; i++) begin
      @(negedge clk);
      chk({tag, " r_valid held"}, 32'(r_valid), 1);
      chk({tag, " rdata held"}, r_data, exp_d);
      chk({tag, " rresp held"}, 32'(r_resp), 32'(exp_r));
      chk({tag, " ar_ready held low"}, 32'(ar_ready), 0);
    end
    r_ready = 1'b1;
    @(negedge clk);
    r_ready = 1'b0;
    chk({tag, " r_valid drop"}, 32'(r_valid), 0);
  endtask

  task automatic check_readies(input string tag, input logic [31:0] exp);
    chk({tag, " ar_ready"}, 32'(ar_ready), exp);
    chk({tag, " aw_ready"}, 32'(aw_ready), exp);
    chk({tag, " w_ready"},  32'(w_ready),  exp);
  endtask

  initial begin
    rst = 1'b1;
    ar_valid = 1'b0; ar_addr = '0; r_ready = 1'b0;
    aw_valid = 1'b0; aw_addr = '0; w_valid = 1'b0; w_data = '0; w_strb = '0; b_ready = 1'b0;

    #3;
    check_readies("reset", 0);
    chk("reset r_valid", 32'(r_valid), 0);
    chk("reset b_valid", 32'(b_valid), 0);
    chk("reset rdata", r_data, 0);
    chk("reset rresp", 32'(r_resp), 0);
    chk("reset bresp", 32'(b_resp), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_readies("release", 1);

    wr("wr full", 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, 2'b00);
    rd("rd full", 32'h8000_0010, 0, 32'hDEAD_BEEF, 2'b00);

    wr("wr partial", 32'h8000_0010, 32'h0000_1234, 4'b0011, 3, 0, 2'b00);
    rd("rd partial", 32'h8000_0010, 0, 32'hDEAD_1234, 2'b00);
    rd("rd low bits ignored", 32'h8000_0013, 0, 32'hDEAD_1234, 2'b00);

    rd("rd miss", 32'h0000_0000, 0, 32'h0, 2'b11);
    rd("rd miss above window", 32'h8000_0400, 0, 32'h0, 2'b11);
    wr("wr word0", 32'h8000_0000, 32'h0BAD_F00D, 4'hF, 0, 0, 2'b00);
    wr("wr top word", 32'h8000_03FC, 32'hCAFE_F00D, 4'hF, 0, 0, 2'b00);
    wr("wr miss", 32'h9000_0000, 32'hFFFF_FFFF, 4'hF, 0, 0, 2'b11);
    rd("rd word0 after miss", 32'h8000_0000, 0, 32'h0BAD_F00D, 2'b00);
    rd("rd word4 after miss", 32'h8000_0010, 0, 32'hDEAD_1234, 2'b00);
    rd("rd top word", 32'h8000_03FC, 0, 32'hCAFE_F00D, 2'b00);

    rd("rd backpressure", 32'h8000_0010, 5, 32'hDEAD_1234, 2'b00);
    wr("wr backpressure", 32'h8000_0014, 32'hAAAA_AAAA, 4'hF, 0, 4, 2'b00);
    wr("wr zero strobe", 32'h8000_0014, 32'h5555_5555, 4'h0, 0, 0, 2'b00);
    rd("rd after zero strobe", 32'h8000_0014, 0, 32'hAAAA_AAAA, 2'b00);

    // Read capture lands on the same edge as the write commit
    fork
      wr("wr same word", 32'h8000_0014, 32'h1111_1111, 4'hF, 0, 0, 2'b00);
      begin
        @(negedge clk);
        rd("rd same word old", 32'h8000_0014, 0, 32'hAAAA_AAAA, 2'b00);
      end
    join
    rd("rd same word new", 32'h8000_0014, 0, 32'h1111_1111, 2'b00);

    fork
      wr("wr word6 concurrent", 32'h8000_0018, 32'h6666_6666, 4'hF, 0, 0, 2'b00);
      rd("rd word4 concurrent", 32'h8000_0010, 0, 32'hDEAD_1234, 2'b00);
    join
    rd("rd word6", 32'h8000_0018, 0, 32'h6666_6666, 2'b00);

    // Reset while a read waits on its latency
    ar_addr = 32'h8000_0010; ar_valid = 1'b1;
    @(negedge clk);
    ar_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_readies("rst rd_wait", 0);
    chk("rst rd_wait r_valid", 32'(r_valid), 0);
    chk("rst rd_wait rdata", r_data, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_readies("rst rd_wait release", 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst rd dropped", 32'(r_valid), 0);
    end

    // Reset while a write sits in commit
    aw_addr = 32'h8000_0010; w_data = 32'h5555_5555; w_strb = 4'hF;
    aw_valid = 1'b1; w_valid = 1'b1; b_ready = 1'b1;
    @(negedge clk);
    aw_valid = 1'b0; w_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_readies("rst wr_commit", 0);
    chk("rst wr_commit b_valid", 32'(b_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_readies("rst wr_commit release", 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst wr dropped", 32'(b_valid), 0);
    end
    b_ready = 1'b0;
    rd("rd after wr reset", 32'h8000_0010, 0, 32'hDEAD_1234, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/axi4_lite_s_mem.md
# axi4_lite_s_mem

AXI4-Lite responder (slave) backed by a word-addressed, byte-writable memory. It answers the AR/R and AW/W/B channels that our AXI4-Lite initiator drives, and serves as the instruction/data memory model and bus-endpoint test target in the multi-cycle core. Read and write channels run independent state machines, each with one transaction outstanding. Read latency is configurable.

## Interface
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width (word = 4 bytes)
- MASK_WIDTH, 4, write-strobe width (DATA_WIDTH/8)
- RESP_WIDTH, 2, response width
- DEPTH_LOG2, 8, log2 of word count (256 words = 1 KiB)
- BASE_ADDR, 32'h8000_0000, base of the decoded window; aligned to 4<<DEPTH_LOG2
- RD_LAT, 2, cycles from the AR handshake to RVALID; legal range 1..15

- iClock  in  1  sole clock, rising edge
- iReset  in  1  asynchronous, active-high reset
- pAXI4S_ar_valid / pAXI4S_ar_ready / pAXI4S_ar_bits_addr  in/out/in  1/1/ADDR_WIDTH  read address channel
- pAXI4S_r_valid / pAXI4S_r_ready  out/in  1/1  read data handshake
- pAXI4S_r_bits_data / pAXI4S_r_bits_resp  out  DATA_WIDTH/RESP_WIDTH  read data and response
- pAXI4S_aw_valid / pAXI4S_aw_ready / pAXI4S_aw_bits_addr  in/out/in  1/1/ADDR_WIDTH  write address channel
- pAXI4S_w_valid / pAXI4S_w_ready  in/out  1/1  write data handshake
- pAXI4S_w_bits_data / pAXI4S_w_bits_strb  in  DATA_WIDTH/MASK_WIDTH  write data and byte strobes
- pAXI4S_b_valid / pAXI4S_b_ready  out/in  1/1  write response handshake
- pAXI4S_b_bits_resp  out  RESP_WIDTH  write response

## Operation
- Handshake: a transfer occurs on a rising edge where valid && ready. Outputs do not depend combinationally on any input valid or ready.
- Decode: an address hits when addr[ADDR_WIDTH-1:DEPTH_LOG2+2] == BASE_ADDR[same bits].
  - Word index = addr[DEPTH_LOG2+1:2].
  - addr[1:0] is ignored, so accesses are word-aligned.
  - A hit returns resp OKAY (2'b00). A miss returns DECERR (2'b11).
- Read FSM: RD_IDLE -> RD_WAIT -> RD_RESP -> RD_IDLE.
  - RD_IDLE: ar_ready=1. On the AR handshake, latch the address, latch the hit flag, and capture the memory word (or 0 on a miss) into the R data register. Load the latency counter with RD_LAT-1.
  - RD_WAIT: ar_ready=0. Decrement the counter each cycle. Move to RD_RESP when the counter is 0. With RD_LAT=1, RD_WAIT lasts one cycle.
  - RD_RESP: r_valid=1. r_bits_data and r_bits_resp are held stable until the R handshake, then return to RD_IDLE.
- Write FSM: WR_IDLE -> WR_COMMIT -> WR_RESP -> WR_IDLE.
  - WR_IDLE: aw_ready = !aw_got and w_ready = !w_got. Each channel is latched independently, in either order or in the same cycle.
  - When both AW and W are held, or both arrive on the current edge, move to WR_COMMIT.
  - WR_COMMIT: both readies are 0. On the next edge:
    - On a hit, write byte i iff strb[i]. strb=0 leaves memory unchanged and still returns OKAY.
    - On a miss, memory is untouched and b_resp=DECERR.
    - Set b_valid=1, clear aw_got and w_got, and move to WR_RESP.
  - WR_RESP: b_valid=1 until the B handshake, then return to WR_IDLE.
- Channels are independent. A write committing on the same edge as a read capture to the same word is not visible to that read (the read returns old data).
- Memory is not reset; its contents are undefined until written.

## Timing
- While iReset=1:
  - Both FSMs are forced to IDLE, aw_got and w_got are cleared, and the counter is cleared.
  - r_valid=0, b_valid=0, r_bits_data=0, r_bits_resp=0, b_bits_resp=0.
  - ar_ready, aw_ready and w_ready are gated to 0.
- Reset takes effect asynchronously, including mid-transaction. Any in-flight transaction is dropped with no response.
- The first cycle after release shows ar_ready=aw_ready=w_ready=1.
- Read latency: AR handshake on edge T gives r_valid high from edge T+RD_LAT. The next AR is accepted no earlier than the edge after the R handshake.
- Write latency: the last of AW/W handshakes on edge T gives memory update and b_valid on edge T+1. The next AW/W is accepted no earlier than the edge after the B handshake.
- Back-to-back throughput with ready held high:
  - Reads: one per RD_LAT+2 cycles.
  - Writes: one per 3 cycles.

## Test plan
- Write and read back:
  - Reset, then AW and W in the same cycle: addr 0x8000_0010, data 0xDEAD_BEEF, strb 4'hF, b_ready=1. Expect b_valid one cycle later with b_resp=00.
  - Then read 0x8000_0010 with r_ready=1. Expect r_valid exactly 2 cycles after the AR handshake, rdata=0xDEAD_BEEF, rresp=00.
- Partial strobe, W leads AW:
  - Present W 3 cycles before AW: data 0x0000_1234, strb 4'b0011, same address. Expect w_ready low after the W handshake and until B completes.
  - Read back gives 0xDEAD_1234.
- Decode miss:
  - Read 0x0000_0000: expect rdata=0, rresp=11.
  - Write 0x9000_0000: expect bresp=11, and every word in the window is unchanged.
- Backpressure:
  - Hold r_ready=0 for 5 cycles after r_valid. Expect r_valid, rdata and rresp stable and ar_ready=0 throughout.
  - Hold b_ready=0 for 4 cycles. Expect b_valid and bresp stable.
- Concurrency:
  - Write 0x1111_1111 to word 5 while reading word 5 in the same cycle (word 5 previously 0xAAAA_AAAA). Expect the read to return 0xAAAA_AAAA; a later read returns 0x1111_1111.
  - Reads and writes to different words finish with independent latencies.
- Reset mid-operation:
  - Assert iReset during RD_WAIT and during WR_COMMIT (between clock edges). Expect r_valid and b_valid 0 immediately, all readies 0, no memory write, and all readies 1 in the first cycle after release.
